// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock through a single
// WIDTH+1-bit subtractor, behind a Start/Done handshake.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StZero, StDone} state_e;

    state_e           state_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   t_diff;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;

    // One restoring step: shift in the next dividend bit, trial-subtract, keep on no borrow.
    always_comb begin
        r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        t_diff  = r_shift - {1'b0, d_q};
        r_d     = r_shift;
        q_d     = {q_q[WIDTH-2:0], 1'b0};
        if (!t_diff[WIDTH]) begin
            r_d = t_diff;
            q_d = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        r_q   <= '0;
                        q_q   <= a_i;
                        d_q   <= b_i;
                        cnt_q <= '0;
                        if (b_i == '0) begin
                            state_q <= StZero;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastIter) begin
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= q_d;
                        remainder_q <= r_d[WIDTH-1:0];
                        dbz_q       <= 1'b0;
                    end
                end
                // Divide-by-zero bypasses the datapath; q_q still holds the captured dividend.
                StZero: begin
                    state_q     <= StDone;
                    done_q      <= 1'b1;
                    quotient_q  <= '1;
                    remainder_q <= q_q;
                    dbz_q       <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and sweep checks of seq_restoring_divider at WIDTH=4: latency, handshake,
// divide-by-zero, ignored Start while busy, back-to-back issue and mid-run reset.
module tb_seq_restoring_divider;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             div_by_zero_o;

    int n_checks = 0;
    int n_fails  = 0;

    seq_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .quotient_o   (quotient_o),
        .remainder_o  (remainder_o),
        .div_by_zero_o(div_by_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        tick();
        start_i = 1'b0;
    endtask

    // Counts edges after acceptance until Done, and samples where Busy was high.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!done_o && lat < 20) begin
            if (busy_o) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic run_div(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int exp_q, input int exp_r, input int exp_z,
                           input int exp_lat, input int exp_busy);
        int lat;
        int bc;
        start_op(a, b);
        wait_done(lat, bc);
        check_eq({tag, " latency"}, lat, exp_lat);
        check_eq({tag, " busy cycles"}, bc, exp_busy);
        check_eq({tag, " quotient"}, quotient_o, exp_q);
        check_eq({tag, " remainder"}, remainder_o, exp_r);
        check_eq({tag, " div_by_zero"}, div_by_zero_o, exp_z);
        tick();
        check_eq({tag, " done single pulse"}, done_o, 0);
    endtask

    initial begin
        int lat;
        int bc;
        rst_n   = 1'b0;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        repeat (3) tick();
        check_eq("reset busy", busy_o, 0);
        check_eq("reset done", done_o, 0);
        check_eq("reset quotient", quotient_o, 0);
        check_eq("reset remainder", remainder_o, 0);
        check_eq("reset dbz", div_by_zero_o, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        check_eq("idle done", done_o, 0);

        run_div("13/4", 4'd13, 4'd4, 3, 1, 0, 4, 4);
        run_div("15/1", 4'd15, 4'd1, 15, 0, 0, 4, 4);
        run_div("5/7", 4'd5, 4'd7, 0, 5, 0, 4, 4);
        run_div("0/3", 4'd0, 4'd3, 0, 0, 0, 4, 4);
        run_div("9/0", 4'd9, 4'd0, 15, 9, 1, 1, 0);
        run_div("15/15", 4'd15, 4'd15, 1, 0, 0, 4, 4);

        // Exhaustive sweep of all nonzero divisors.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                start_op(4'(a), 4'(b));
                wait_done(lat, bc);
                check_eq($sformatf("sweep %0d/%0d latency", a, b), lat, WIDTH);
                check_eq($sformatf("sweep %0d/%0d quotient", a, b), quotient_o, a / b);
                check_eq($sformatf("sweep %0d/%0d remainder", a, b), remainder_o, a % b);
                tick();
                check_eq($sformatf("sweep %0d/%0d done pulse", a, b), done_o, 0);
            end
        end

        // Start during RUN is dropped; Start held in the Done cycle is accepted.
        start_op(4'd14, 4'd3);
        tick();
        start_i = 1'b1;
        a_i     = 4'd7;
        b_i     = 4'd2;
        tick();
        start_i = 1'b0;
        check_eq("ignored start busy", busy_o, 1);
        lat = 0;
        while (!done_o && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("14/3 after ignored start done", done_o, 1);
        check_eq("14/3 quotient", quotient_o, 4);
        check_eq("14/3 remainder", remainder_o, 2);
        start_op(4'd7, 4'd2);
        check_eq("back-to-back done drops", done_o, 0);
        check_eq("back-to-back busy", busy_o, 1);
        wait_done(lat, bc);
        check_eq("back-to-back latency", lat, WIDTH);
        check_eq("7/2 quotient", quotient_o, 3);
        check_eq("7/2 remainder", remainder_o, 1);
        tick();

        // Reset in the middle of a division aborts it with no Done.
        start_op(4'd11, 4'd2);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("async reset busy", busy_o, 0);
        check_eq("async reset quotient", quotient_o, 0);
        check_eq("async reset remainder", remainder_o, 0);
        check_eq("async reset dbz", div_by_zero_o, 0);
        bc = 0;
        repeat (2) begin
            tick();
            if (done_o) bc++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            if (done_o) bc++;
        end
        check_eq("no done after reset", bc, 0);
        run_div("11/2 after reset", 4'd11, 4'd2, 5, 1, 0, 4, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
